sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter FW, default 32, frequency word and sweep-config width.
REQ-002 Parameter CW, default 32, dwell (cycle) counter width.
REQ-003 Parameter DEB_CYC, default 1_000_000, clocks a key must be stable before acceptance.
REQ-004 Parameter N_WAVE, default 3, number of waveform selections; sel_wave width.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 key_mode  in  1  raw active-low key; cycles operating mode.
REQ-008 key_wave  in  1  raw active-low key; cycles waveform select.
REQ-009 key_run  in  1  raw active-low key; start/pause/resume sweep.
REQ-010 cfg_start, cfg_end, cfg_step  in  FW each  external sweep start, end, step words.
REQ-011 cfg_cycle  in  CW  external dwell, clocks per step.
REQ-012 cfg_loop  in  1  external mode: 1 = restart at end, 0 = one-shot.
REQ-013 fre_k  out  FW  registered DDS frequency tuning word.
REQ-014 sel_wave  out  N_WAVE  registered active-low one-hot waveform select.
REQ-015 mode  out  2  current mode (FIXED=0, EXT=1, PRESET=2).
REQ-016 sweeping  out  1  high while sweep state is RUN.
REQ-017 sweep_done  out  1  one-cycle pulse when a one-shot sweep completes.

Function
REQ-018 Each key SHALL be 2-FF synchronised, debounced (DEB_CYC stable clocks), and produce a one-clock press pulse on the debounced 1->0 edge; no logic SHALL be clocked by a key.
REQ-019 Mode FSM SHALL advance FIXED->EXT->PRESET->FIXED on each key_mode press.
REQ-020 In FIXED, fre_k SHALL equal FIX_FREQ (34300) and sweep state SHALL be STOPPED.
REQ-021 On entering EXT, cfg_* SHALL be latched in the transition cycle; on entering PRESET, preset constants SHALL be loaded; fre_k SHALL become the latched start the following cycle; sweep state STOPPED.
REQ-022 Sweep FSM states STOPPED, RUN, PAUSED; key_run press (EXT/PRESET only): STOPPED->RUN with restart (re-latch cfg_* in EXT, fre_k<=start, dwell and step counters cleared); RUN->PAUSED (fre_k held); PAUSED->RUN (resume, counters kept).
REQ-023 In RUN the dwell counter SHALL count 0..cycle-1 and issue a step tick when it equals cycle-1, then wrap to 0; cycle=0 SHALL behave as 1.
REQ-024 On a step tick with fre_k<end: next = fre_k+step computed FW+1 bits; if next>end or carry set, fre_k<=end, else fre_k<=next.
REQ-025 On a step tick with fre_k>=end: loop=1 -> fre_k<=start; loop=0 -> STOPPED, fre_k held, sweep_done pulsed that cycle.
REQ-026 PRESET step SHALL be P_STEP0 for the first P_NSLOW ticks after restart, P_STEP1 thereafter; PRESET loop=0.
REQ-027 cfg_start>cfg_end SHALL give fre_k=start and complete on the first tick per REQ-025.
REQ-028 key_mode press mid-sweep SHALL abort: state STOPPED, no sweep_done, new mode values applied per REQ-020/021.
REQ-029 Simultaneous key_mode and key_run pulses: mode SHALL win; run pulse discarded.
REQ-030 cfg_* changes during RUN/PAUSED SHALL be ignored until next restart or EXT entry.
REQ-031 key_wave press SHALL increment wave index modulo N_WAVE; sel_wave = ~(1<<index), registered, any mode.

Reset
REQ-032 rst_n low SHALL immediately force: mode FIXED, sweep STOPPED, fre_k=FIX_FREQ, wave index 0 (sel_wave all ones except bit 0), sweeping 0, sweep_done 0, all counters 0, debouncers in released (1) state.
REQ-033 Reset mid-sweep SHALL produce no sweep_done pulse; release resumes in FIXED.

Structure
REQ-034 Shared package dds_pkg SHALL hold the mode and sweep-state enums, FIX_FREQ, and presets P_START=34300, P_END=3430000, P_STEP0=8575, P_STEP1=452760, P_NSLOW=20, P_CYCLE=93_750_000.
REQ-035 Sub-module key_debounce (sync, debounce, press pulse, param DEB_CYC) SHALL be instantiated once per key.

Verification (DEB_CYC=4)
REQ-036 Reset, no keys -> fre_k=34300, mode=0, sel_wave=3'b110, sweeping=0.
REQ-037 EXT, start=100, end=130, step=10, cycle=3, loop=0, key_run -> fre_k 100,110,120,130 every 3 clocks, then sweep_done one pulse, sweeping=0.
REQ-038 Same with end=125 -> fre_k 100,110,120,125 (clamp), then done; loop=1 -> returns to 100.
REQ-039 PRESET run, P_CYCLE overridden to 2 -> 20 steps of 8575, then steps of 452760, clamps at 3430000, stops.
REQ-040 key_run mid-sweep holds fre_k; second press resumes next step on schedule; key_mode + key_run same cycle -> mode EXT->PRESET, no run.
REQ-041 Key bounce shorter than 4 clocks -> no press; three key_wave presses -> sel_wave 101, 011, 110.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller: mode and sweep-state
// enums, the fixed frequency and the built-in preset sweep.
package dds_pkg;

  typedef enum logic [1:0] {
    ModeFixed  = 2'd0,
    ModeExt    = 2'd1,
    ModePreset = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    SwStopped = 2'd0,
    SwRun     = 2'd1,
    SwPaused  = 2'd2
  } sweep_e;

  localparam int unsigned FIX_FREQ = 34300;
  localparam int unsigned P_START  = 34300;
  localparam int unsigned P_END    = 3430000;
  localparam int unsigned P_STEP0  = 8575;
  localparam int unsigned P_STEP1  = 452760;
  localparam int unsigned P_NSLOW  = 20;
  localparam int unsigned P_CYCLE  = 93_750_000;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      ModeFixed: return ModeExt;
      ModeExt:   return ModePreset;
      default:   return ModeFixed;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key: 2-FF synchroniser, stability debouncer, one-clock press
// pulse on the debounced 1->0 edge.
module key_debounce #(
  parameter int unsigned DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEB_CYC + 1);

  logic [1:0]      sync_q;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key};
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= deb_q & ~deb_d;
    end
  end

  // Accept the new level only after DEB_CYC consecutive clocks of disagreement.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntW'(DEB_CYC - 1)) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/sweep_ctrl.sv
// DDS frequency sweep controller: mode FSM (fixed/external/preset), sweep FSM
// with dwell timing and end clamping, and waveform select, all driven by keys.
module sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FW         = 32,
  parameter int unsigned CW         = 32,
  parameter int unsigned DEB_CYC    = 1_000_000,
  parameter int unsigned N_WAVE     = 3,
  parameter int unsigned PRESET_CYC = P_CYCLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_mode,
  input  logic              key_wave,
  input  logic              key_run,
  input  logic [FW-1:0]     cfg_start,
  input  logic [FW-1:0]     cfg_end,
  input  logic [FW-1:0]     cfg_step,
  input  logic [CW-1:0]     cfg_cycle,
  input  logic              cfg_loop,
  output logic [FW-1:0]     fre_k,
  output logic [N_WAVE-1:0] sel_wave,
  output logic [1:0]        mode,
  output logic              sweeping,
  output logic              sweep_done
);

  localparam int unsigned WaveW = (N_WAVE > 1) ? $clog2(N_WAVE) : 1;
  localparam int unsigned NsW   = $clog2(P_NSLOW + 1);

  logic mode_p, wave_p, run_p;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (.clk(clk), .rst_n(rst_n), .key(key_mode),
                                                .press(mode_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_wave (.clk(clk), .rst_n(rst_n), .key(key_wave),
                                                .press(wave_p));
  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_run  (.clk(clk), .rst_n(rst_n), .key(key_run),
                                                .press(run_p));

  mode_e       mode_q, mode_d;
  sweep_e      sw_q, sw_d;
  logic [FW-1:0] fre_q, fre_d, start_q, start_d, end_q, end_d, step_q, step_d;
  logic [CW-1:0] cycle_q, cycle_d, dwell_q, dwell_d;
  logic          loop_q, loop_d, done_q, done_d;
  logic [NsW-1:0]   nslow_q, nslow_d;
  logic [WaveW-1:0] wave_q, wave_d;
  logic [N_WAVE-1:0] sel_q, sel_d;

  logic [CW-1:0] cycle_eff;
  logic [FW-1:0] step_eff;
  logic [FW:0]   sum;
  logic          tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= ModeFixed;
      sw_q    <= SwStopped;
      fre_q   <= FW'(FIX_FREQ);
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      cycle_q <= '0;
      loop_q  <= 1'b0;
      dwell_q <= '0;
      nslow_q <= '0;
      done_q  <= 1'b0;
      wave_q  <= '0;
      sel_q   <= ~N_WAVE'(1);
    end else begin
      mode_q  <= mode_d;
      sw_q    <= sw_d;
      fre_q   <= fre_d;
      start_q <= start_d;
      end_q   <= end_d;
      step_q  <= step_d;
      cycle_q <= cycle_d;
      loop_q  <= loop_d;
      dwell_q <= dwell_d;
      nslow_q <= nslow_d;
      done_q  <= done_d;
      wave_q  <= wave_d;
      sel_q   <= sel_d;
    end
  end

  // A zero dwell is treated as one clock per step.
  assign cycle_eff = (cycle_q == '0) ? CW'(1) : cycle_q;
  assign tick      = (dwell_q == cycle_eff - CW'(1));
  assign step_eff  = (mode_q != ModePreset) ? step_q :
                     (nslow_q < NsW'(P_NSLOW)) ? FW'(P_STEP0) : FW'(P_STEP1);
  assign sum       = {1'b0, fre_q} + {1'b0, step_eff};

  always_comb begin
    mode_d  = mode_q;
    sw_d    = sw_q;
    fre_d   = fre_q;
    start_d = start_q;
    end_d   = end_q;
    step_d  = step_q;
    cycle_d = cycle_q;
    loop_d  = loop_q;
    dwell_d = dwell_q;
    nslow_d = nslow_q;
    done_d  = 1'b0;

    // Mode press has priority and aborts any sweep; a coincident run press is dropped.
    if (mode_p) begin
      mode_d  = next_mode(mode_q);
      sw_d    = SwStopped;
      dwell_d = '0;
      nslow_d = '0;
      unique case (mode_d)
        ModeExt: begin
          start_d = cfg_start;
          end_d   = cfg_end;
          step_d  = cfg_step;
          cycle_d = cfg_cycle;
          loop_d  = cfg_loop;
          fre_d   = cfg_start;
        end
        ModePreset: begin
          start_d = FW'(P_START);
          end_d   = FW'(P_END);
          step_d  = FW'(P_STEP0);
          cycle_d = CW'(PRESET_CYC);
          loop_d  = 1'b0;
          fre_d   = FW'(P_START);
        end
        default: fre_d = FW'(FIX_FREQ);
      endcase
    end else if (run_p && (mode_q != ModeFixed)) begin
      unique case (sw_q)
        SwStopped: begin
          sw_d    = SwRun;
          dwell_d = '0;
          nslow_d = '0;
          if (mode_q == ModeExt) begin
            start_d = cfg_start;
            end_d   = cfg_end;
            step_d  = cfg_step;
            cycle_d = cfg_cycle;
            loop_d  = cfg_loop;
            fre_d   = cfg_start;
          end else begin
            fre_d = start_q;
          end
        end
        SwRun:    sw_d = SwPaused;
        SwPaused: sw_d = SwRun;
        default:  sw_d = SwStopped;
      endcase
    end else if (sw_q == SwRun) begin
      dwell_d = tick ? '0 : dwell_q + CW'(1);
      if (tick) begin
        if (nslow_q < NsW'(P_NSLOW)) nslow_d = nslow_q + NsW'(1);
        if (fre_q < end_q) begin
          fre_d = (sum[FW] || (sum[FW-1:0] > end_q)) ? end_q : sum[FW-1:0];
        end else if (loop_q) begin
          fre_d = start_q;
        end else begin
          sw_d   = SwStopped;
          done_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wave_d = wave_q;
    if (wave_p) begin
      wave_d = (wave_q == WaveW'(N_WAVE - 1)) ? '0 : wave_q + WaveW'(1);
    end
    sel_d = ~(N_WAVE'(1) << wave_d);
  end

  assign fre_k      = fre_q;
  assign sel_wave   = sel_q;
  assign mode       = mode_q;
  assign sweeping   = (sw_q == SwRun);
  assign sweep_done = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: table of external sweeps checked through a
// scoreboard queue, plus hand sequences for pause/resume, key collisions, preset, reset.
module tb_sweep_ctrl;

  localparam int unsigned DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode, key_wave, key_run;
  logic [31:0] cfg_start, cfg_end, cfg_step, cfg_cycle;
  logic        cfg_loop;
  logic [31:0] fre_k;
  logic [2:0]  sel_wave;
  logic [1:0]  mode;
  logic        sweeping, sweep_done;

  sweep_ctrl #(
    .FW(32), .CW(32), .DEB_CYC(DEB), .N_WAVE(3), .PRESET_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_wave(key_wave), .key_run(key_run),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_step(cfg_step), .cfg_cycle(cfg_cycle),
    .cfg_loop(cfg_loop), .fre_k(fre_k), .sel_wave(sel_wave), .mode(mode),
    .sweeping(sweeping), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) if (sweep_done === 1'b1) done_cnt++;

  typedef struct {
    logic [31:0]      st, en, sp, cy;
    logic             lp, dn;
    int               n;
    logic [5:0][31:0] ex;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(input logic [31:0] st, en, sp, cy, input logic lp, dn,
                              input int n, input logic [31:0] e0, e1, e2, e3, e4, e5);
    vec_t v;
    v.st = st; v.en = en; v.sp = sp; v.cy = cy; v.lp = lp; v.dn = dn; v.n = n;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3; v.ex[4] = e4; v.ex[5] = e5;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tap(input int k);
    @(negedge clk);
    case (k)
      0: key_mode = 1'b0;
      1: key_wave = 1'b0;
      default: key_run = 1'b0;
    endcase
    repeat (DEB + 6) @(negedge clk);
    case (k)
      0: key_mode = 1'b1;
      1: key_wave = 1'b1;
      default: key_run = 1'b1;
    endcase
    repeat (DEB + 6) @(negedge clk);
  endtask

  // Press run, then pop and compare each new fre_k value and its spacing.
  task automatic run_sweep(input int cyc, input bit exp_done);
    int t, last_t, t0;
    logic [31:0] prev, last_exp;
    bit got;
    fork tap(2); join_none
    t = 0;
    while (!sweeping && t < 40) begin @(negedge clk); t++; end
    chk("run_start", sweeping, 1);
    last_exp = exp_q.pop_front();
    chk("start_val", fre_k, last_exp);
    prev = fre_k; last_t = 0; t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(negedge clk); t++;
      if (fre_k !== prev) begin
        last_exp = exp_q.pop_front();
        chk("step_val", fre_k, last_exp);
        chk("step_gap", t - last_t, cyc);
        last_t = t; prev = fre_k;
      end
    end
    if (exp_q.size() > 0) begin
      chk("step_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (exp_done) begin
      t0 = t; got = 1'b0;
      while (!got && t < t0 + cyc + 4) begin
        @(negedge clk); t++;
        if (sweep_done) got = 1'b1;
      end
      chk("done_pulse", got, 1);
      chk("done_gap", t - last_t, cyc);
      chk("done_stopped", sweeping, 0);
      chk("done_hold", fre_k, last_exp);
      @(negedge clk);
      chk("done_one_cycle", sweep_done, 0);
    end
    repeat (2 * DEB + 14) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, nchg, snap;
    logic [31:0] v, nv;
    vt[0] = mk(100, 130, 10, 3, 0, 1, 4, 100, 110, 120, 130, 0, 0);
    vt[1] = mk(100, 125, 10, 3, 0, 1, 4, 100, 110, 120, 125, 0, 0);
    vt[2] = mk(100, 125, 10, 3, 1, 0, 6, 100, 110, 120, 125, 100, 110);
    vt[3] = mk(200, 150, 10, 3, 0, 1, 1, 200, 0, 0, 0, 0, 0);
    vt[4] = mk(10, 13, 1, 0, 0, 1, 4, 10, 11, 12, 13, 0, 0);
    vt[5] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 0, 1, 2,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0);

    rst_n = 1'b0; key_mode = 1'b1; key_wave = 1'b1; key_run = 1'b1;
    cfg_start = '0; cfg_end = '0; cfg_step = '0; cfg_cycle = '0; cfg_loop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fre_k", fre_k, 34300);
    chk("rst_mode", mode, 0);
    chk("rst_sel_wave", sel_wave, 3'b110);
    chk("rst_sweeping", sweeping, 0);
    chk("rst_done", sweep_done, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_fre_k", fre_k, 34300);

    // Bounces of 3 clocks must not register as presses.
    for (int i = 0; i < 3; i++) begin
      key_wave = 1'b0; repeat (3) @(negedge clk);
      key_wave = 1'b1; repeat (6) @(negedge clk);
    end
    chk("bounce_sel", sel_wave, 3'b110);
    tap(1); chk("wave1", sel_wave, 3'b101);
    tap(1); chk("wave2", sel_wave, 3'b011);
    tap(1); chk("wave3", sel_wave, 3'b110);

    for (int i = 0; i < 6; i++) begin
      cfg_start = vt[i].st; cfg_end = vt[i].en; cfg_step = vt[i].sp;
      cfg_cycle = vt[i].cy; cfg_loop = vt[i].lp;
      tap(0);
      chk("ext_mode", mode, 1);
      chk("ext_latch", fre_k, vt[i].st);
      chk("ext_stopped", sweeping, 0);
      for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].ex[j]);
      run_sweep((vt[i].cy == 0) ? 1 : int'(vt[i].cy), vt[i].dn);
      snap = done_cnt;
      tap(0);
      chk("abort_mode", mode, 2);
      chk("abort_stopped", sweeping, 0);
      chk("abort_no_done", done_cnt, snap);
      chk("preset_load", fre_k, 34300);
      tap(0);
      chk("fixed_mode", mode, 0);
      chk("fixed_fre", fre_k, 34300);
    end

    // Pause / resume, with cfg changed while paused.
    cfg_start = 100; cfg_end = 200; cfg_step = 10; cfg_cycle = 4; cfg_loop = 0;
    tap(0);
    @(negedge clk); key_run = 1'b0; t = 0;
    while (!sweeping && t < 40) begin @(negedge clk); t++; end
    chk("pr_run", sweeping, 1);
    key_run = 1'b1;
    repeat (10) @(negedge clk);
    key_run = 1'b0; t = 0;
    while (sweeping && t < 40) begin @(negedge clk); t++; end
    chk("pr_paused", sweeping, 0);
    v = fre_k;
    chk("pr_progressed", (v >= 110 && v <= 190 && v % 10 == 0), 1);
    cfg_step = 50; key_run = 1'b1; nchg = 0;
    repeat (20) begin @(negedge clk); if (fre_k !== v) nchg++; end
    chk("pr_hold", nchg, 0);
    key_run = 1'b0; t = 0;
    while (!sweeping && t < 40) begin @(negedge clk); t++; end
    chk("pr_resume", sweeping, 1);
    t = 0;
    while (fre_k === v && t < 10) begin @(negedge clk); t++; end
    chk("pr_gap", (t >= 1 && t <= 4), 1);
    chk("pr_next", fre_k, v + 10);
    key_run = 1'b1;
    repeat (10) @(negedge clk);
    tap(0); tap(0); tap(0);
    chk("pr_ext_again", mode, 1);

    // Coincident mode and run presses: mode wins.
    @(negedge clk); key_mode = 1'b0; key_run = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    key_mode = 1'b1; key_run = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    chk("coll_mode", mode, 2);
    chk("coll_no_run", sweeping, 0);
    chk("coll_fre", fre_k, 34300);

    // Preset sweep: 20 slow steps, then fast steps clamped at the end word.
    v = 34300; exp_q.push_back(v);
    for (int i = 0; i < 20; i++) begin v = v + 8575; exp_q.push_back(v); end
    while (v < 3430000) begin
      nv = v + 452760;
      v = (nv > 3430000) ? 32'd3430000 : nv;
      exp_q.push_back(v);
    end
    run_sweep(2, 1);
    tap(0);
    chk("preset_to_fixed", mode, 0);

    // Reset in the middle of a sweep.
    cfg_start = 500; cfg_end = 5000; cfg_step = 1; cfg_cycle = 5; cfg_loop = 0;
    tap(0);
    fork tap(2); join_none
    t = 0;
    while (!sweeping && t < 40) begin @(negedge clk); t++; end
    chk("rs_run", sweeping, 1);
    repeat (2 * DEB + 14) @(negedge clk);
    snap = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_mode", mode, 0);
    chk("rs_fre", fre_k, 34300);
    chk("rs_sweeping", sweeping, 0);
    chk("rs_done", sweep_done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rs_no_done", done_cnt, snap);
    chk("rs_fixed", mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
